// File: rtl/keypad_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan_if
// Purpose  : Pad-side and event-side signals of the 4x4 keypad scanner.
// Revision : 1.0 - initial release
// ============================================================================
interface keypad_scan_if;
    logic        enable;
    logic [3:0]  col_n;
    logic [3:0]  row_oe;
    logic [15:0] key_state;
    logic        ev_valid;
    logic [3:0]  ev_code;
    logic        ev_ready;
    logic        overflow;
    logic        ovf_clr;

    modport master (
        input  enable, col_n, ev_ready, ovf_clr,
        output row_oe, key_state, ev_valid, ev_code, overflow
    );

    modport slave (
        output enable, col_n, ev_ready, ovf_clr,
        input  row_oe, key_state, ev_valid, ev_code, overflow
    );
endinterface
`default_nettype wire

// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan_ctrl
// Purpose  : Row-scan, debounce and 4-deep press-event queue for a 4x4 keypad.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scan_ctrl #(
    parameter int SETTLE_CYC = 25000,
    parameter int GAP_CYC    = 24996,
    parameter int DEBOUNCE   = 3
) (
    input  wire logic     CLOCK_50,
    input  wire logic     reset,
    keypad_scan_if.master bus
);
    localparam int              c_CNT_MAX     = (SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC;
    localparam int              c_CW          = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CW-1:0] c_SETTLE_LAST = c_CW'(SETTLE_CYC - 1);
    localparam logic [c_CW-1:0] c_GAP_LAST    = c_CW'(GAP_CYC - 1);
    localparam logic [3:0]      c_DEBOUNCE    = 4'(DEBOUNCE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    state_t          r_state;
    logic [1:0]      r_row;
    logic [1:0]      r_col;
    logic [c_CW-1:0] r_cnt;
    logic [3:0]      r_row_oe;
    logic [3:0]      r_col_s1;
    logic [3:0]      r_col_s2;
    logic [3:0]      r_raw;

    logic [15:0]      r_key_state;
    logic [15:0][3:0] r_db;

    logic [3:0][3:0] r_mem;
    logic [1:0]      r_wr;
    logic [1:0]      r_rd;
    logic [2:0]      r_count;
    logic            r_ovf;

    logic [1:0] w_next_row;
    logic [3:0] w_raw_vec;
    logic       w_raw_bit;
    logic       w_eval;
    logic [3:0] w_key;
    logic [3:0] w_db_inc;
    logic       w_flip;
    logic       w_push;
    logic       w_full;
    logic       w_pop;
    logic       w_wr;
    logic       w_drop;

    // Column pins are asynchronous to CLOCK_50; released (high) out of reset.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_col_s1 <= 4'hF;
            r_col_s2 <= 4'hF;
        end else begin
            r_col_s1 <= bus.col_n;
            r_col_s2 <= r_col_s1;
        end
    end

    assign w_next_row = r_row + 2'd1;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_row    <= 2'd0;
            r_col    <= 2'd0;
            r_cnt    <= '0;
            r_row_oe <= 4'b0000;
            r_raw    <= 4'b0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_row    <= 2'd0;
                    r_row_oe <= 4'b0000;
                    if (bus.enable) begin
                        r_state  <= ST_DRIVE;
                        r_cnt    <= '0;
                        r_row_oe <= 4'b0001;
                    end
                end
                ST_DRIVE: begin
                    if (r_cnt == c_SETTLE_LAST) begin
                        r_state <= ST_SAMPLE;
                        r_cnt   <= '0;
                        r_col   <= 2'd0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (r_col == 2'd0) begin
                        r_raw <= ~r_col_s2;
                    end
                    r_col <= r_col + 2'd1;
                    if (r_col == 2'd3) begin
                        r_state  <= ST_GAP;
                        r_cnt    <= '0;
                        r_row_oe <= 4'b0000;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == c_GAP_LAST) begin
                        r_cnt <= '0;
                        // Losing enable mid-scan parks the scanner once this row is done.
                        if (!bus.enable) begin
                            r_state <= ST_IDLE;
                            r_row   <= 2'd0;
                        end else begin
                            r_state  <= ST_DRIVE;
                            r_row    <= w_next_row;
                            r_row_oe <= 4'b0001 << w_next_row;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_row_oe <= 4'b0000;
                end
            endcase
        end
    end

    // Column 0 is judged on the live synchronized value; later columns on the captured copy.
    assign w_raw_vec = (r_col == 2'd0) ? ~r_col_s2 : r_raw;
    assign w_raw_bit = w_raw_vec[r_col];
    assign w_eval    = (r_state == ST_SAMPLE);
    assign w_key     = {r_row, r_col};
    assign w_db_inc  = r_db[w_key] + 4'd1;
    assign w_flip    = w_eval && (w_raw_bit != r_key_state[w_key]) && (w_db_inc == c_DEBOUNCE);
    assign w_push    = w_flip && w_raw_bit;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_key_state <= 16'h0000;
            r_db        <= '0;
        end else if (w_eval) begin
            if (w_raw_bit == r_key_state[w_key]) begin
                r_db[w_key] <= 4'd0;
            end else if (w_flip) begin
                r_key_state[w_key] <= w_raw_bit;
                r_db[w_key]        <= 4'd0;
            end else begin
                r_db[w_key] <= w_db_inc;
            end
        end
    end

    assign w_full = (r_count == 3'd4);
    assign w_pop  = (r_count != 3'd0) && bus.ev_ready;
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_drop = w_push && w_full && !w_pop;

    // When full, the write slot equals the head slot; a same-cycle pop frees it.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_mem   <= '0;
            r_wr    <= 2'd0;
            r_rd    <= 2'd0;
            r_count <= 3'd0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr] <= w_key;
                r_wr        <= r_wr + 2'd1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 2'd1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (bus.ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.row_oe    = r_row_oe;
    assign bus.key_state = r_key_state;
    assign bus.ev_valid  = (r_count != 3'd0);
    assign bus.ev_code   = (r_count != 3'd0) ? r_mem[r_rd] : 4'd0;
    assign bus.overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scan_ctrl
// Purpose  : Directed self-checking bench for keypad_scan_ctrl with a keypad matrix model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_ctrl;
    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [15:0] keys;
    int          n_cmp = 0;
    int          n_err = 0;

    keypad_scan_if kif ();

    keypad_scan_ctrl #(
        .SETTLE_CYC (4),
        .GAP_CYC    (4),
        .DEBOUNCE   (2)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (kif)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // A pressed key shorts its column to a row that is being driven low.
    function automatic logic [3:0] pad_cols(input logic [3:0] oe, input logic [15:0] pressed);
        logic [3:0] v;
        v = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (oe[r] && pressed[4*r+c]) v[c] = 1'b0;
        return v;
    endfunction

    assign kif.col_n = pad_cols(kif.row_oe, keys);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_oe(input logic [3:0] val, input string tag);
        int n;
        n = 0;
        while (kif.row_oe !== val && n < 200) begin
            @(negedge CLOCK_50);
            n++;
        end
        chk(tag, {28'd0, kif.row_oe}, {28'd0, val});
    endtask

    task automatic row_done(input int r);
        logic [3:0] oh;
        oh = 4'b0001 << r;
        wait_oe(oh, "wait_row_drive");
        wait_oe(4'b0000, "wait_row_gap");
    endtask

    task automatic pop_expect(input logic [3:0] code, input string tag);
        chk({tag, "_valid"}, {31'd0, kif.ev_valid}, 32'd1);
        chk({tag, "_code"}, {28'd0, kif.ev_code}, {28'd0, code});
        kif.ev_ready = 1'b1;
        @(negedge CLOCK_50);
        kif.ev_ready = 1'b0;
    endtask

    task automatic press_release(input int k);
        keys = 16'h0000;
        keys[k] = 1'b1;
        row_done(k / 4);
        row_done(k / 4);
        keys = 16'h0000;
        row_done(k / 4);
        row_done(k / 4);
    endtask

    initial begin
        reset        = 1'b1;
        keys         = 16'h0000;
        kif.enable   = 1'b0;
        kif.ev_ready = 1'b0;
        kif.ovf_clr  = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        reset      = 1'b0;
        kif.enable = 1'b1;

        // 1: reset while row 1 is driven, then the first row period after release
        wait_oe(4'b0010, "reach_row1");
        #1 reset = 1'b1;
        #1;
        chk("rst_row_oe", {28'd0, kif.row_oe}, 32'd0);
        chk("rst_key_state", {16'd0, kif.key_state}, 32'd0);
        chk("rst_ev_valid", {31'd0, kif.ev_valid}, 32'd0);
        chk("rst_ev_code", {28'd0, kif.ev_code}, 32'd0);
        chk("rst_overflow", {31'd0, kif.overflow}, 32'd0);
        @(negedge CLOCK_50);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLOCK_50);
            chk("row0_drive", {28'd0, kif.row_oe}, 32'h1);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge CLOCK_50);
            chk("row0_gap", {28'd0, kif.row_oe}, 32'h0);
        end
        @(negedge CLOCK_50);
        chk("row1_start", {28'd0, kif.row_oe}, 32'h2);

        // 2: single press of key 6
        keys = 16'h0040;
        row_done(1);
        chk("k6_first_sample", {16'd0, kif.key_state}, 32'h0);
        chk("k6_first_valid", {31'd0, kif.ev_valid}, 32'd0);
        row_done(1);
        chk("k6_state", {16'd0, kif.key_state}, 32'h0040);
        pop_expect(4'd6, "k6_event");
        chk("k6_popped", {31'd0, kif.ev_valid}, 32'd0);
        for (int i = 0; i < 5; i++) row_done(1);
        chk("k6_hold_no_event", {31'd0, kif.ev_valid}, 32'd0);
        chk("k6_hold_state", {16'd0, kif.key_state}, 32'h0040);
        keys = 16'h0000;
        row_done(1);
        chk("k6_release_1", {16'd0, kif.key_state}, 32'h0040);
        row_done(1);
        chk("k6_release_2", {16'd0, kif.key_state}, 32'h0);
        chk("k6_release_no_event", {31'd0, kif.ev_valid}, 32'd0);

        // 3: key 9 bounces low for single samples only
        for (int i = 0; i < 2; i++) begin
            keys = 16'h0200;
            row_done(2);
            keys = 16'h0000;
            row_done(2);
        end
        chk("k9_bounce_state", {16'd0, kif.key_state}, 32'h0);
        chk("k9_bounce_valid", {31'd0, kif.ev_valid}, 32'd0);

        // 4: keys 12 and 15 together
        keys = 16'h9000;
        row_done(3);
        row_done(3);
        chk("k12_15_state", {16'd0, kif.key_state}, 32'h9000);
        pop_expect(4'd12, "k12_event");
        pop_expect(4'd15, "k15_event");
        chk("k12_15_drained", {31'd0, kif.ev_valid}, 32'd0);
        keys = 16'h0000;
        row_done(3);
        row_done(3);
        chk("k12_15_released", {16'd0, kif.key_state}, 32'h0);
        chk("k12_15_no_release_ev", {31'd0, kif.ev_valid}, 32'd0);

        // 5: overflow with a full FIFO, then simultaneous push and pop
        press_release(0);
        press_release(1);
        press_release(2);
        press_release(3);
        chk("full_no_ovf", {31'd0, kif.overflow}, 32'd0);
        press_release(5);
        chk("ovf_set", {31'd0, kif.overflow}, 32'd1);
        pop_expect(4'd0, "ovf_pop0");
        pop_expect(4'd1, "ovf_pop1");
        pop_expect(4'd2, "ovf_pop2");
        pop_expect(4'd3, "ovf_pop3");
        chk("ovf_drained", {31'd0, kif.ev_valid}, 32'd0);
        chk("ovf_sticky", {31'd0, kif.overflow}, 32'd1);
        kif.ovf_clr = 1'b1;
        @(negedge CLOCK_50);
        kif.ovf_clr = 1'b0;
        chk("ovf_cleared", {31'd0, kif.overflow}, 32'd0);

        keys = 16'h000F;
        row_done(0);
        row_done(0);
        chk("refill_head", {28'd0, kif.ev_code}, 32'd0);
        keys = 16'h002F;
        row_done(1);
        wait_oe(4'b0000, "sim_gap");
        wait_oe(4'b0010, "sim_row1");
        repeat (5) @(negedge CLOCK_50);
        kif.ev_ready = 1'b1;
        @(negedge CLOCK_50);
        kif.ev_ready = 1'b0;
        chk("sim_no_drop", {31'd0, kif.overflow}, 32'd0);
        pop_expect(4'd1, "sim_pop1");
        pop_expect(4'd2, "sim_pop2");
        pop_expect(4'd3, "sim_pop3");
        pop_expect(4'd5, "sim_pop5");
        chk("sim_drained", {31'd0, kif.ev_valid}, 32'd0);

        // 6: enable dropped during row 2 DRIVE
        wait_oe(4'b0000, "en_gap");
        wait_oe(4'b0100, "en_row2");
        kif.enable = 1'b0;
        repeat (7) @(negedge CLOCK_50);
        chk("en_row2_sample_end", {28'd0, kif.row_oe}, 32'h4);
        @(negedge CLOCK_50);
        chk("en_row2_gap", {28'd0, kif.row_oe}, 32'h0);
        repeat (60) @(negedge CLOCK_50);
        chk("en_idle_row_oe", {28'd0, kif.row_oe}, 32'h0);
        chk("en_idle_key_state", {16'd0, kif.key_state}, 32'h002F);
        kif.enable = 1'b1;
        @(negedge CLOCK_50);
        chk("en_restart_row0", {28'd0, kif.row_oe}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scan controller for the 4x4 GPIO keypad. It sequences row drive, column sampling, per-key debounce and press-event queuing, and presents debounced key presses through a ready/valid interface. It sits between the GPIO tristate pads and the segment-display/LED consumers. Those consumers pop key codes instead of edge-triggering on a raw flag.

## Interface
Parameters:
- SETTLE_CYC, 25000: cycles a row is driven before its columns are captured. Must be ≥ 3 to cover the 2-FF synchronizer.
- GAP_CYC, 24996: cycles all rows are released after a row's sample phase.
- DEBOUNCE, 3: consecutive differing samples of a key required to change its state. Range 1..15.

Ports:
- CLOCK_50, in, 1: system clock. Everything is on the rising edge.
- reset, in, 1: asynchronous, active-high reset.
- enable, in, 1: scanning runs while high.
- col_n, in, 4: column pins, pulled up; low means pressed in the driven row. Asynchronous.
- row_oe, out, 4: one-hot. 1 means the pad drives that row to 0; 0 means hi-Z. The block never drives 1.
- key_state, out, 16: debounced pressed map. Bit index = 4*row+col.
- ev_valid, out, 1: event FIFO not empty.
- ev_code, out, 4: FIFO head key code (4*row+col). Valid while ev_valid.
- ev_ready, in, 1: consumer pops the head when ev_valid && ev_ready.
- overflow, out, 1: sticky flag. A press was dropped because the FIFO was full.
- ovf_clr, in, 1: clears overflow.

## Operation
Column synchronizer:
- col_n passes through 2 flops.
- Reset value of both flops is 4'b1111 (released).

FSM states, with row index r (0..3), phase counter cnt and column index c:
- IDLE: row_oe=0, r=0. Goes to DRIVE when enable=1.
- DRIVE: row_oe[r]=1 for SETTLE_CYC cycles, then goes to SAMPLE.
- SAMPLE: 4 cycles with row_oe[r] still 1.
  - On entry, capture the inverted synchronized columns into raw[3:0].
  - Each cycle c=0..3 evaluates key k=4*r+c against raw[c].
  - Then goes to GAP.
- GAP: row_oe=0 for GAP_CYC cycles.
  - If r<3: r+1, go to DRIVE.
  - If r==3: r=0; go to DRIVE if enable=1, else IDLE.
- enable falling mid-scan: the current row finishes through GAP, then the FSM goes to IDLE with r=0.
- key_state and FIFO contents are kept while idle.

Debounce, one counter per key, evaluated only in that key's SAMPLE cycle:
- raw==key_state[k]: counter is set to 0.
- Otherwise: counter+1. When counter+1 == DEBOUNCE, flip key_state[k] and set the counter to 0.
- A 0→1 flip is a press: push k into the FIFO.
- A 1→0 flip is a release: no event.

Event FIFO: 4 entries, first-in first-out.
- Push and pop in the same cycle is always legal, including when the FIFO is full.
- Push when full with no pop: the code is dropped and overflow is set.
- ovf_clr and a new drop in the same cycle: overflow stays 1.

Reset (asynchronous) forces:
- FSM to IDLE, r/cnt/c = 0, row_oe=0.
- key_state=0, all debounce counters 0.
- FIFO empty: ev_valid=0, ev_code=0.
- overflow=0.

Reset mid-row releases row_oe immediately.

## Timing
- Row period = SETTLE_CYC + 4 + GAP_CYC cycles. Full scan = 4 row periods. Defaults give 1 ms per row.
- row_oe changes on the clock edge that enters DRIVE/GAP and is registered.
- Column capture uses the synchronized value present in the first SAMPLE cycle. A pin change is visible 2 cycles after it occurs.
- Press latency is measured from the SAMPLE cycle evaluating key k on its DEBOUNCE-th consecutive differing sample. At the next edge key_state[k]=1 and, if the FIFO was empty, ev_valid=1 with ev_code=k.
- Pop: ev_valid && ev_ready at an edge advances the head. The new head, or ev_valid=0, is visible after that edge.
- ev_code is stable while ev_valid=1 and no pop occurs.
- Minimum press-to-event time is (DEBOUNCE-1) full scans plus position in scan.

## Test plan
Bench overrides: SETTLE_CYC=4, GAP_CYC=4, DEBOUNCE=2 (row period 12, scan 48).
1. **Reset mid-DRIVE:** assert reset while row_oe=0010 → row_oe=0, key_state=0, ev_valid=0, overflow=0 without waiting for a clock. Release reset with enable=1 → row_oe=0001 for 8 cycles, then 0000 for 4, then 0010.
2. **Single press:** enable=1; hold col_n[2]=0 whenever row_oe[1]=1.
   - Second row-1 sample: key_state=0x0040, ev_valid=1, ev_code=6.
   - ev_ready=1 for one cycle → ev_valid=0.
   - Continued holding for 5 scans → no new event.
   - Release for 2 scans → key_state=0.
3. **Bounce rejection:** key 9 low for exactly one row-2 sample, then high → key_state stays 0 and ev_valid stays 0.
4. **Same-row multi-press:** keys 12 and 15 pressed together → both events queued in order 12, 15. key_state=0x9000.
5. **Overflow:** ev_ready=0; press-release keys 0, 1, 2, 3, 5 in turn.
   - FIFO holds 0, 1, 2, 3 and overflow=1.
   - Pops return 0, 1, 2, 3, then ev_valid=0.
   - ovf_clr=1 → overflow=0.
   - Full FIFO with simultaneous push and pop → no drop.
6. **Enable drop:** deassert enable during row 2 DRIVE → row 2 completes SAMPLE and GAP, then row_oe=0 indefinitely. Re-assert → scanning restarts at row 0 (row_oe=0001).
